// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding and requester ids shared by the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ACC = 2'b01, S_RESP = 2'b10} state_t;
  localparam logic ID_IF = 1'b0;
  localparam logic ID_D = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way picker, fixed data priority or round-robin on ties
module rr_arb2 import mem_arb_pkg::*; #(
  parameter bit DPRIO = 1'b0
) (
  input  logic if_req,
  input  logic d_req,
  input  logic last_gnt,
  output logic gnt,
  output logic any
);
  assign any = if_req | d_req;
  assign gnt = (if_req & d_req) ? (DPRIO ? ID_D : ~last_gnt) : (d_req ? ID_D : ID_IF);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between fetch and load/store ports
module mem_arbiter import mem_arb_pkg::*; #(
  parameter bit DPRIO = 1'b0,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clka,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_req,
  input  logic [3:0]    d_wea,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          mem_ena,
  output logic [3:0]    mem_wea,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dina,
  input  logic [DW-1:0] mem_douta,
  output logic          stall
);
  state_t state, state_nx;
  logic last_gnt, gnt_id, gnt, any;
  logic [AW-1:0] lat_addr;
  logic [3:0] lat_wea;
  logic [DW-1:0] lat_wdata, if_rdata_q, d_rdata_q;
  rr_arb2 #(.DPRIO(DPRIO)) u_arb (
    .if_req(if_req),
    .d_req(d_req),
    .last_gnt(last_gnt),
    .gnt(gnt),
    .any(any)
  );
  // state register; reset aborts any access in flight
  always_ff @(posedge clka)
    state <= !rst ? S_IDLE : state_nx;
  // IDLE waits for a request, ACC and RESP each last exactly one cycle
  always_comb begin
    state_nx = S_IDLE;
    if (state == S_IDLE && any) state_nx = S_ACC;
    else if (state == S_ACC) state_nx = S_RESP;
  end
  // latch the winner on grant and hold the last returned word per port
  always_ff @(posedge clka)
    if (!rst) begin
      last_gnt   <= ID_D;
      gnt_id     <= ID_IF;
      lat_addr   <= '0;
      lat_wea    <= '0;
      lat_wdata  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (state == S_IDLE && any) begin
        gnt_id    <= gnt;
        last_gnt  <= gnt;
        lat_addr  <= gnt == ID_D ? d_addr : if_addr;
        lat_wea   <= gnt == ID_D ? d_wea : 4'h0;
        lat_wdata <= d_wdata;
      end
      if (if_done) if_rdata_q <= mem_douta;
      if (d_done) d_rdata_q <= mem_douta;
    end
  assign mem_ena  = state == S_ACC;
  assign mem_wea  = (mem_ena ? lat_wea : 4'h0) & {4{rst}};
  assign mem_addr = lat_addr;
  assign mem_dina = lat_wdata;
  assign if_done  = state == S_RESP && gnt_id == ID_IF;
  assign d_done   = state == S_RESP && gnt_id == ID_D;
  assign if_rdata = if_done ? mem_douta : if_rdata_q;
  assign d_rdata  = d_done ? mem_douta : d_rdata_q;
  assign stall    = (if_req | d_req) & ~(if_done | d_done);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, timing, byte writes and reset abort
module tb_mem_arbiter;
  logic clka = 1'b0;
  logic rst = 1'b0;
  logic if_req = 1'b0, d_req = 1'b0, p_if_req = 1'b0, p_d_req = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_douta = '0, p_douta = '0;
  logic [3:0] d_wea = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_dina;
  logic [31:0] p_if_rdata, p_d_rdata, p_addr, p_dina;
  logic if_done, d_done, mem_ena, stall;
  logic p_if_done, p_d_done, p_ena, p_stall;
  logic [3:0] mem_wea, p_wea;
  logic [31:0] ram [0:63];
  int ncmp = 0;
  int nerr = 0;

  always #5 clka = ~clka;

  mem_arbiter #(.DPRIO(1'b0), .AW(32), .DW(32)) dut (
    .clka(clka), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_wea(d_wea), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addr(mem_addr), .mem_dina(mem_dina),
    .mem_douta(mem_douta), .stall(stall)
  );

  mem_arbiter #(.DPRIO(1'b1), .AW(32), .DW(32)) dut_p (
    .clka(clka), .rst(rst),
    .if_req(p_if_req), .if_addr(if_addr), .if_rdata(p_if_rdata), .if_done(p_if_done),
    .d_req(p_d_req), .d_wea(4'h0), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(p_d_rdata), .d_done(p_d_done),
    .mem_ena(p_ena), .mem_wea(p_wea), .mem_addr(p_addr), .mem_dina(p_dina),
    .mem_douta(p_douta), .stall(p_stall)
  );

  always @(posedge clka)
    if (mem_ena) begin
      for (int b = 0; b < 4; b++)
        if (mem_wea[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_dina[8*b +: 8];
      mem_douta <= ram[mem_addr[7:2]];
    end

  task automatic nxt;
    @(posedge clka);
    #1;
  endtask

  task automatic smp;
    @(negedge clka);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic acc_d(input logic [3:0] wea, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp, input string tag);
    nxt;
    d_req = 1'b1; d_wea = wea; d_addr = addr; d_wdata = wdata;
    smp;
    chk({tag, "_stall0"}, stall, 1);
    nxt;
    smp;
    chk({tag, "_ena"}, mem_ena, 1);
    chk({tag, "_wea"}, mem_wea, {28'h0, wea});
    chk({tag, "_addr"}, mem_addr, addr);
    if (wea != 4'h0) chk({tag, "_dina"}, mem_dina, wdata);
    nxt;
    smp;
    chk({tag, "_done"}, d_done, 1);
    chk({tag, "_stall2"}, stall, 0);
    if (wea == 4'h0) chk({tag, "_rdata"}, d_rdata, exp);
    nxt;
    d_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = '0;
    ram[1] = 32'h20020005;
    ram[2] = 32'h11112222;
    if_req = 1'b1; d_req = 1'b1; p_if_req = 1'b1; p_d_req = 1'b1;
    if_addr = 32'h4; d_addr = 32'h8;
    repeat (3) begin
      nxt;
      smp;
      chk("rst_ctl", {25'h0, mem_ena, mem_wea, if_done, d_done}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_dina", mem_dina, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_stall", stall, 1);
      chk("rst_p_ctl", {29'h0, p_ena, p_if_done, p_d_done}, 0);
    end
    nxt;
    rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) nxt;
      smp;
      chk($sformatf("rr_if_done_c%0d", i), if_done, (i == 2 || i == 8) ? 1 : 0);
      chk($sformatf("rr_d_done_c%0d", i), d_done, (i == 5) ? 1 : 0);
      chk($sformatf("rr_ena_c%0d", i), mem_ena, (i % 3 == 1) ? 1 : 0);
      chk($sformatf("rr_stall_c%0d", i), stall, (i % 3 == 2) ? 0 : 1);
      chk($sformatf("pr_d_done_c%0d", i), p_d_done, (i % 3 == 2) ? 1 : 0);
      chk($sformatf("pr_if_done_c%0d", i), p_if_done, 0);
      if (i == 2) chk("rr_if_rdata", if_rdata, 32'h20020005);
      if (i == 5) chk("rr_d_rdata", d_rdata, 32'h11112222);
    end
    nxt;
    if_req = 1'b0; d_req = 1'b0; p_d_req = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) nxt;
      smp;
      chk($sformatf("pr_if_after_c%0d", j), p_if_done, (j == 2) ? 1 : 0);
      chk($sformatf("pr_d_after_c%0d", j), p_d_done, 0);
    end
    nxt;
    p_if_req = 1'b0;
    nxt;
    if_req = 1'b1; if_addr = 32'h4;
    smp;
    chk("lf_stall0", stall, 1);
    chk("lf_ena0", mem_ena, 0);
    nxt;
    smp;
    chk("lf_ena1", mem_ena, 1);
    chk("lf_addr1", mem_addr, 32'h4);
    chk("lf_wea1", mem_wea, 0);
    chk("lf_stall1", stall, 1);
    nxt;
    smp;
    chk("lf_done2", if_done, 1);
    chk("lf_rdata2", if_rdata, 32'h20020005);
    chk("lf_stall2", stall, 0);
    chk("lf_d_done2", d_done, 0);
    nxt;
    if_req = 1'b0;
    smp;
    chk("lf_done3", if_done, 0);
    chk("lf_hold3", if_rdata, 32'h20020005);
    chk("lf_stall3", stall, 0);
    acc_d(4'hF, 32'h54, 32'hDEADBEEF, 32'h0, "st_word");
    acc_d(4'h0, 32'h54, 32'h0, 32'hDEADBEEF, "ld_word");
    acc_d(4'h1, 32'h54, 32'h000000AA, 32'h0, "st_byte");
    acc_d(4'h0, 32'h54, 32'h0, 32'hDEADBEAA, "ld_byte");
    nxt;
    d_req = 1'b1; d_wea = 4'hF; d_addr = 32'h54; d_wdata = 32'h12345678;
    smp;
    nxt;
    rst = 1'b0;
    smp;
    chk("rw_wea_blocked", mem_wea, 0);
    nxt;
    smp;
    chk("rw_no_done", {30'h0, if_done, d_done}, 0);
    chk("rw_idle_ena", mem_ena, 0);
    nxt;
    rst = 1'b1; d_req = 1'b0;
    smp;
    chk("rw_after_ena", mem_ena, 0);
    acc_d(4'h0, 32'h54, 32'h0, 32'hDEADBEAA, "rw_reload");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one single-port synchronous RAM (the unified `inst_ram`/`data_ram` replacement) between the MIPS instruction-fetch port and the load/store port. Each request is latched, issued to the RAM for one cycle, and answered with a one-cycle `done` pulse carrying read data. Contention is resolved by fixed data priority or two-way round-robin. A `stall` output freezes the core while any of its requests is outstanding.

## Interface
- `DPRIO`, 0: 1 = data port always wins ties; 0 = round-robin.
- `AW`, 32: address width.
- `DW`, 32: data width.

- `clka` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `if_req` in 1: fetch request, held until `if_done`.
- `if_addr` in AW: fetch address.
- `if_rdata` out DW: fetched word, valid while `if_done`=1.
- `if_done` out 1: one-cycle completion pulse.
- `d_req` in 1: data request, held until `d_done`.
- `d_wea` in 4: byte write enables; 0 = read.
- `d_addr` in AW: data address.
- `d_wdata` in DW: store data.
- `d_rdata` out DW: load data, valid while `d_done`=1.
- `d_done` out 1: one-cycle completion pulse.
- `mem_ena` out 1: RAM enable.
- `mem_wea` out 4: RAM byte write enables.
- `mem_addr` out AW: RAM address, passed through unaltered.
- `mem_dina` out DW: RAM write data.
- `mem_douta` in DW: RAM read data, one-cycle latency after the sampling edge.
- `stall` out 1: `(if_req|d_req) & ~(if_done|d_done)`.

## Operation
- FSM states:
  - IDLE → ACC when any request is present; the winner's id, address, `wea` and `wdata` are latched.
  - ACC → RESP unconditionally.
  - RESP → IDLE unconditionally.
- Arbitration in IDLE:
  - Single request: granted.
  - Tie, `DPRIO`=1: data port wins.
  - Tie, `DPRIO`=0: the port not in `last_gnt` wins. `last_gnt` updates on every grant and resets to DATA, so the first tie goes to fetch.
- ACC: `mem_ena`=1 and `mem_addr`/`mem_dina` come from the latched registers.
  - `mem_wea` = latched `wea` & {4{`rst`}}. A write is suppressed combinationally during reset.
  - A fetch always issues `wea`=0.
- RESP:
  - `mem_douta` is captured into the granted port's rdata register.
  - That port's `done`=1 for this cycle only.
  - Writes also complete in RESP; rdata for a write is don't-care but is driven with `mem_douta`.
- Requests are sampled only in IDLE. A request raised during ACC/RESP waits. A requester dropping `req` before `done` is a protocol violation; the access still completes.
- A requester may hold `req` high through the cycle after `done`; it is then re-arbitrated as a new request.

## Timing
- Latency: request present at edge n (IDLE) → ACC in cycle n+1 → `done` and rdata in cycle n+2.
- Throughput: one access per 3 cycles. Worst-case fetch wait under a tie is 6 cycles.
- Reset values: state=IDLE, `last_gnt`=DATA; `mem_ena`, `mem_wea`, `mem_addr`, `mem_dina`, `if_done`, `d_done`, `if_rdata`, `d_rdata` all 0. `stall` follows its combinational equation.
- Reset mid-operation: the next edge forces IDLE with no `done` pulse. The aborted requester must re-request. The RAM write in an ACC cycle with `rst`=0 is blocked.
- `stall` is combinational from `req` and `done`. There is no path from `mem_douta` to `stall`.

## Structure
- Package `mem_arb_pkg`:
  - state constants S_IDLE=2'b00, S_ACC=2'b01, S_RESP=2'b10.
  - requester ids ID_IF=1'b0, ID_D=1'b1.
- Sub-module `rr_arb2`: combinational two-input picker. Inputs are the two requests, `last_gnt` and `DPRIO`; outputs are grant id and `any`. `last_gnt` is held in `mem_arbiter`.
- The FSM, latch registers and response registers live in `mem_arbiter`.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with both requests high → all registered outputs 0, no `mem_ena`, state IDLE.
- **Lone fetch:** RAM[0x4]=0x20020005, `if_req` at `if_addr`=0x4 → `mem_ena`=1 and `mem_addr`=0x4 in cycle 1; `if_done`=1 and `if_rdata`=0x20020005 in cycle 2; `stall`=1 in cycles 0-1 and 0 in cycle 2.
- **Round-robin tie, `DPRIO`=0:** both requests raised and held after reset → fetch completes cycle 2, data cycle 5, fetch cycle 8 (alternating).
- **Fixed priority, `DPRIO`=1:** both requests held → data is served on every grant; fetch is served only once `d_req` drops.
- **Store then load:** `d_wea`=4'hF, `d_addr`=0x54, `d_wdata`=0xDEADBEEF → `mem_wea`=4'hF in ACC. A following read of 0x54 → `d_rdata`=0xDEADBEEF. Then a byte store with `d_wea`=4'h1 and `d_wdata`=0x000000AA → a read returns 0xDEADBEAA.
- **Reset during write:** `rst`=0 in the ACC cycle of a store of 0x12345678 to 0x54 → `mem_wea`=0, no `d_done`. After reset, a read of 0x54 returns the old value.
